// File: rtl/motion_search_engine.sv
// Full-search block-matching motion estimator.
// Each group of NUM_PE candidates is scored over a FETCH/DRAIN pass, and the
// lanes are then compared serially in raster order against the running best.
module motion_search_engine #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned BLK    = 16,
  parameter int unsigned RANGE  = 8,
  parameter int unsigned NUM_PE = 16,
  localparam int unsigned SW    = BLK + 2 * RANGE,
  localparam int unsigned ACC_W = PIX_W + 2 * $clog2(BLK),
  localparam int unsigned MV_W  = $clog2(RANGE) + 1,
  localparam int unsigned RA_W  = $clog2(BLK * BLK),
  localparam int unsigned SA_W  = $clog2(SW * SW)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ACC_W-1:0]         thresh,
  output logic                     busy,
  output logic                     done,
  output logic [RA_W-1:0]          r_addr,
  input  logic [PIX_W-1:0]         r_data,
  output logic [SA_W-1:0]          s_addr,
  input  logic [NUM_PE*PIX_W-1:0]  s_data,
  output logic [ACC_W-1:0]         best_sad,
  output logic signed [MV_W-1:0]   mv_x,
  output logic signed [MV_W-1:0]   mv_y,
  output logic                     early
);

  localparam int unsigned NPOS = 2 * RANGE;
  localparam int unsigned NCG  = NPOS / NUM_PE;
  localparam int unsigned LN_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned CY_W = (NPOS > 1) ? $clog2(NPOS) : 1;
  localparam int unsigned CG_W = (NCG > 1) ? $clog2(NCG) : 1;
  localparam logic [MV_W-1:0] MV_MIN = MV_W'(32'd0 - RANGE);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, COMPARE, FIN} state_t;

  state_t                    state_q, state_n;
  logic [RA_W-1:0]           pix_q, pix_n;
  logic [LN_W-1:0]           lane_q, lane_n;
  logic [CY_W-1:0]           cy_q, cy_n;
  logic [CG_W-1:0]           cg_q, cg_n;
  logic [ACC_W-1:0]          acc_q [NUM_PE];
  logic [ACC_W-1:0]          acc_n [NUM_PE];
  logic [PIX_W-1:0]          diff  [NUM_PE];
  logic [ACC_W-1:0]          best_q, best_n;
  logic signed [MV_W-1:0]    vx_q, vx_n, vy_q, vy_n;
  logic [ACC_W-1:0]          thr_q, thr_n;
  logic                      busy_n, done_n, early_n;
  logic [ACC_W-1:0]          best_sad_n;
  logic signed [MV_W-1:0]    mv_x_n, mv_y_n;
  logic [RA_W-1:0]           r_addr_n;
  logic [SA_W-1:0]           s_addr_n;

  // Window address of reference pixel p for group (cy, cg), lane 0
  function automatic logic [SA_W-1:0] win_addr(input logic [RA_W-1:0] p,
                                               input logic [CY_W-1:0] cy,
                                               input logic [CG_W-1:0] cg);
    int unsigned x;
    int unsigned y;
    x = 32'(p) % BLK;
    y = 32'(p) / BLK;
    return SA_W'((y + 32'(cy)) * SW + x + 32'(cg) * NUM_PE);
  endfunction

  // Per-lane absolute difference of the returning reference and window pixels
  always_comb begin
    for (int k = 0; k < NUM_PE; k++) begin
      if (r_data >= s_data[k*PIX_W +: PIX_W])
        diff[k] = r_data - s_data[k*PIX_W +: PIX_W];
      else
        diff[k] = s_data[k*PIX_W +: PIX_W] - r_data;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_n    = state_q;
    pix_n      = pix_q;
    lane_n     = lane_q;
    cy_n       = cy_q;
    cg_n       = cg_q;
    acc_n      = acc_q;
    best_n     = best_q;
    vx_n       = vx_q;
    vy_n       = vy_q;
    thr_n      = thr_q;
    done_n     = 1'b0;
    early_n    = early;
    best_sad_n = best_sad;
    mv_x_n     = mv_x;
    mv_y_n     = mv_y;
    r_addr_n   = r_addr;
    s_addr_n   = s_addr;

    case (state_q)
      IDLE: begin
        if (start) begin
          thr_n    = thresh;
          best_n   = '1;
          vx_n     = $signed(MV_MIN);
          vy_n     = $signed(MV_MIN);
          cy_n     = '0;
          cg_n     = '0;
          pix_n    = '0;
          r_addr_n = '0;
          s_addr_n = win_addr('0, '0, '0);
          state_n  = FETCH;
        end
      end

      FETCH: begin
        // Data seen at p is the pixel addressed at p-1; p=1 carries pixel 0
        if (pix_q != '0) begin
          for (int k = 0; k < NUM_PE; k++) begin
            if (pix_q == RA_W'(1))
              acc_n[k] = ACC_W'(diff[k]);
            else
              acc_n[k] = acc_q[k] + ACC_W'(diff[k]);
          end
        end
        if (pix_q == RA_W'(BLK * BLK - 1)) begin
          state_n = DRAIN;
        end else begin
          pix_n    = pix_q + RA_W'(1);
          r_addr_n = pix_q + RA_W'(1);
          s_addr_n = win_addr(pix_q + RA_W'(1), cy_q, cg_q);
        end
      end

      DRAIN: begin
        for (int k = 0; k < NUM_PE; k++)
          acc_n[k] = acc_q[k] + ACC_W'(diff[k]);
        lane_n  = '0;
        state_n = COMPARE;
      end

      COMPARE: begin
        // Strict less-than keeps the earliest candidate on ties
        if (acc_q[lane_q] < best_q) begin
          best_n = acc_q[lane_q];
          vx_n   = $signed(MV_W'(32'(cg_q) * NUM_PE + 32'(lane_q) - RANGE));
          vy_n   = $signed(MV_W'(32'(cy_q) - RANGE));
        end
        if (lane_q == LN_W'(NUM_PE - 1)) begin
          if ((thr_q != '0) && (best_n < thr_q)) begin
            early_n    = 1'b1;
            best_sad_n = best_n;
            mv_x_n     = vx_n;
            mv_y_n     = vy_n;
            done_n     = 1'b1;
            state_n    = FIN;
          end else if ((cy_q == CY_W'(NPOS - 1)) && (cg_q == CG_W'(NCG - 1))) begin
            early_n    = 1'b0;
            best_sad_n = best_n;
            mv_x_n     = vx_n;
            mv_y_n     = vy_n;
            done_n     = 1'b1;
            state_n    = FIN;
          end else begin
            if (cg_q == CG_W'(NCG - 1)) begin
              cg_n = '0;
              cy_n = cy_q + CY_W'(1);
            end else begin
              cg_n = cg_q + CG_W'(1);
            end
            pix_n    = '0;
            r_addr_n = '0;
            s_addr_n = win_addr('0, cy_n, cg_n);
            state_n  = FETCH;
          end
        end else begin
          lane_n = lane_q + LN_W'(1);
        end
      end

      FIN: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pix_q    <= '0;
      lane_q   <= '0;
      cy_q     <= '0;
      cg_q     <= '0;
      for (int k = 0; k < NUM_PE; k++) acc_q[k] <= '0;
      best_q   <= '1;
      vx_q     <= '0;
      vy_q     <= '0;
      thr_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      early    <= 1'b0;
      best_sad <= '1;
      mv_x     <= '0;
      mv_y     <= '0;
      r_addr   <= '0;
      s_addr   <= '0;
    end else begin
      state_q  <= state_n;
      pix_q    <= pix_n;
      lane_q   <= lane_n;
      cy_q     <= cy_n;
      cg_q     <= cg_n;
      acc_q    <= acc_n;
      best_q   <= best_n;
      vx_q     <= vx_n;
      vy_q     <= vy_n;
      thr_q    <= thr_n;
      busy     <= busy_n;
      done     <= done_n;
      early    <= early_n;
      best_sad <= best_sad_n;
      mv_x     <= mv_x_n;
      mv_y     <= mv_y_n;
      r_addr   <= r_addr_n;
      s_addr   <= s_addr_n;
    end
  end

endmodule

// File: tb/tb_motion_search_engine.sv
// Scoreboard bench for motion_search_engine: default instance (a) and a
// small BLK=8/RANGE=4/NUM_PE=4 instance (b), each with synchronous memories.
module tb_motion_search_engine;

  typedef struct {
    int sad;
    int mvx;
    int mvy;
    int early;
    int done_cyc;
    int busy_len;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  // Cycle index: value seen in the interval following each rising edge
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- instance a (defaults) ----------------
  logic               start_a;
  logic [15:0]        thresh_a;
  logic               busy_a, done_a, early_a;
  logic [7:0]         r_addr_a;
  logic [7:0]         r_data_a;
  logic [9:0]         s_addr_a;
  logic [127:0]       s_data_a;
  logic [127:0]       s_tmp_a;
  logic [15:0]        best_sad_a;
  logic signed [3:0]  mv_x_a, mv_y_a;
  logic [7:0]         ref_a [256];
  logic [7:0]         win_a [1024];
  exp_t               qa [$];
  int                 bcnt_a = 0;
  int                 done_cnt_a = 0;

  motion_search_engine dut_a (
    .clock(clock), .reset(reset), .start(start_a), .thresh(thresh_a),
    .busy(busy_a), .done(done_a), .r_addr(r_addr_a), .r_data(r_data_a),
    .s_addr(s_addr_a), .s_data(s_data_a), .best_sad(best_sad_a),
    .mv_x(mv_x_a), .mv_y(mv_y_a), .early(early_a)
  );

  // ---------------- instance b (small variant) ----------------
  logic               start_b;
  logic [13:0]        thresh_b;
  logic               busy_b, done_b, early_b;
  logic [5:0]         r_addr_b;
  logic [7:0]         r_data_b;
  logic [7:0]         s_addr_b;
  logic [31:0]        s_data_b;
  logic [31:0]        s_tmp_b;
  logic [13:0]        best_sad_b;
  logic signed [2:0]  mv_x_b, mv_y_b;
  logic [7:0]         ref_b [64];
  logic [7:0]         win_b [256];
  exp_t               qb [$];
  int                 bcnt_b = 0;
  int                 done_cnt_b = 0;

  motion_search_engine #(.PIX_W(8), .BLK(8), .RANGE(4), .NUM_PE(4)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .thresh(thresh_b),
    .busy(busy_b), .done(done_b), .r_addr(r_addr_b), .r_data(r_data_b),
    .s_addr(s_addr_b), .s_data(s_data_b), .best_sad(best_sad_b),
    .mv_x(mv_x_b), .mv_y(mv_y_b), .early(early_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous-read memory models, one cycle of latency
  always @(posedge clock) begin
    int idx;
    for (int k = 0; k < 16; k++) begin
      idx = int'(s_addr_a) + k;
      s_tmp_a[k*8 +: 8] = (idx < 1024) ? win_a[idx[9:0]] : 8'h00;
    end
    for (int k = 0; k < 4; k++) begin
      idx = int'(s_addr_b) + k;
      s_tmp_b[k*8 +: 8] = (idx < 256) ? win_b[idx[7:0]] : 8'h00;
    end
    r_data_a <= ref_a[r_addr_a];
    s_data_a <= s_tmp_a;
    r_data_b <= ref_b[r_addr_b];
    s_data_b <= s_tmp_b;
  end

  // Monitor a: count busy cycles, compare each done against the queue head
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (start_a && !busy_a) bcnt_a = 0;
      if (busy_a) bcnt_a++;
      if (done_a) begin
        done_cnt_a++;
        if (qa.size() == 0) begin
          check("unexpected_done_a", 1, 0);
        end else begin
          e = qa.pop_front();
          check("sad_a", int'(best_sad_a), e.sad);
          check("mvx_a", int'(mv_x_a), e.mvx);
          check("mvy_a", int'(mv_y_a), e.mvy);
          check("early_a", int'(early_a), e.early);
          check("done_cycle_a", cyc, e.done_cyc);
          check("busy_len_a", bcnt_a, e.busy_len);
        end
      end
    end
  end

  // Monitor b
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (start_b && !busy_b) bcnt_b = 0;
      if (busy_b) bcnt_b++;
      if (done_b) begin
        done_cnt_b++;
        if (qb.size() == 0) begin
          check("unexpected_done_b", 1, 0);
        end else begin
          e = qb.pop_front();
          check("sad_b", int'(best_sad_b), e.sad);
          check("mvx_b", int'(mv_x_b), e.mvx);
          check("mvy_b", int'(mv_y_b), e.mvy);
          check("early_b", int'(early_b), e.early);
          check("done_cycle_b", cyc, e.done_cyc);
          check("busy_len_b", bcnt_b, e.busy_len);
        end
      end
    end
  end

  // Pulse start for one cycle and queue the expected result; t = start cycle
  task automatic run_a(input int th, input int sad, input int mx, input int my,
                       input int ea, input int lat, output int t);
    exp_t e;
    @(posedge clock); #1;
    start_a  = 1'b1;
    thresh_a = 16'(th);
    t = cyc;
    e.sad = sad; e.mvx = mx; e.mvy = my; e.early = ea;
    e.done_cyc = t + lat; e.busy_len = lat;
    qa.push_back(e);
    @(posedge clock); #1;
    start_a = 1'b0;
  endtask

  task automatic run_b(input int sad, input int mx, input int my, input int lat);
    exp_t e;
    @(posedge clock); #1;
    start_b  = 1'b1;
    thresh_b = 14'd0;
    e.sad = sad; e.mvx = mx; e.mvy = my; e.early = 0;
    e.done_cyc = cyc + lat; e.busy_len = lat;
    qb.push_back(e);
    @(posedge clock); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int d0;
    int n;
    d0 = done_cnt_a;
    n = 0;
    while (done_cnt_a == d0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    check("done_seen_a", int'(done_cnt_a != d0), 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic wait_done_b(input int budget);
    int d0;
    int n;
    d0 = done_cnt_b;
    n = 0;
    while (done_cnt_b == d0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    check("done_seen_b", int'(done_cnt_b != d0), 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic fill_random_a();
    for (int i = 0; i < 256; i++) ref_a[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) win_a[i] = 8'($urandom);
  endtask

  // Copy the reference into the window at candidate (dx, dy)
  task automatic embed_a(input int dx, input int dy);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        win_a[(y + dy + 8) * 32 + x + dx + 8] = ref_a[y * 16 + x];
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, int'(busy_a), 0);
    check({tag, "_done"}, int'(done_a), 0);
    check({tag, "_early"}, int'(early_a), 0);
    check({tag, "_best_sad"}, int'(best_sad_a), 65535);
    check({tag, "_mv_x"}, int'(mv_x_a), 0);
    check({tag, "_mv_y"}, int'(mv_y_a), 0);
    check({tag, "_r_addr"}, int'(r_addr_a), 0);
    check({tag, "_s_addr"}, int'(s_addr_a), 0);
  endtask

  initial begin
    int t;
    int d0;
    reset    = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    thresh_a = '0;
    thresh_b = '0;
    for (int i = 0; i < 256; i++) ref_a[i] = 8'h00;
    for (int i = 0; i < 1024; i++) win_a[i] = 8'h00;
    for (int i = 0; i < 64; i++) ref_b[i] = 8'h00;
    for (int i = 0; i < 256; i++) win_b[i] = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_reset_a("rst0");
    check("rst0_best_sad_b", int'(best_sad_b), 16383);
    check("rst0_busy_b", int'(busy_b), 0);
    reset = 1'b0;

    // Exact match at (+3, -2)
    fill_random_a();
    embed_a(3, -2);
    run_a(0, 0, 3, -2, 0, 4369, t);
    wait_done_a(4500);

    // Worst-case SAD, every candidate equal: first candidate wins
    for (int i = 0; i < 256; i++) ref_a[i] = 8'h00;
    for (int i = 0; i < 1024; i++) win_a[i] = 8'hFF;
    run_a(0, 65280, -8, -8, 0, 4369, t);
    wait_done_a(4500);

    // Two exact matches at (-1,0) and (2,0): reference periodic in x by 3
    fill_random_a();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        ref_a[y * 16 + x] = 8'(y * 7 + (x % 3) * 50 + 3);
    embed_a(-1, 0);
    embed_a(2, 0);
    run_a(0, 0, -1, 0, 0, 4369, t);
    wait_done_a(4500);

    // Early exit after the first group
    fill_random_a();
    embed_a(5, -8);
    run_a(1, 0, 5, -8, 1, 274, t);
    wait_done_a(400);

    // Same data, threshold off: early clears; a start while busy is ignored
    run_a(0, 0, 5, -8, 0, 4369, t);
    repeat (498) @(posedge clock);
    #1;
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    wait_done_a(4500);
    repeat (20) @(posedge clock);
    #1;

    // Reset in the middle of a search
    run_a(0, 0, 5, -8, 0, 4369, t);
    while (cyc < t + 1000) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_reset_a("rst_mid");
    qa.delete();
    d0 = done_cnt_a;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4500) @(posedge clock);
    #1;
    check("no_done_after_reset", done_cnt_a - d0, 0);
    run_a(0, 0, 5, -8, 0, 4369, t);
    wait_done_a(4500);

    // Small variant: exact match at (-4, 3)
    for (int i = 0; i < 64; i++) ref_b[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) win_b[i] = 8'($urandom);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        win_b[(y + 3 + 4) * 16 + x - 4 + 4] = ref_b[y * 8 + x];
    run_b(0, -4, 3, 1105);
    wait_done_b(1200);

    check("pending_a", qa.size(), 0);
    check("pending_b", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
